// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, TX FIFO, 8N1 serializer.
// Define UART_TX_PARITY_EN to append an even-parity bit (11-bit frames).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        W_en,
    input  logic        R_en,
    input  logic [31:0] addr,
    input  logic [2:0]  RW_type,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        tx,
    output logic        tx_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [31:0]      TXDATA_ADDR = BASE_ADDR;
    localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
`endif

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg, overflow_next;
    logic             full, empty, push, pop, wr_txdata, wr_status;
    logic [7:0]       head;

    state_t           state_reg, state_next;
    logic             tx_reg, tx_next;
    logic [CNT_W-1:0] baud_reg, baud_next;
    logic [7:0]       shift_reg, shift_next;
    logic [2:0]       bit_reg, bit_next;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    // Access size and upper store bytes carry no meaning for byte-wide TX.
    logic unused_inputs;
    assign unused_inputs = ^{RW_type, din[31:8]};

    assign wr_txdata = W_en && (addr == TXDATA_ADDR);
    assign wr_status = W_en && (addr == STATUS_ADDR);
    assign full      = (count_reg == FULL_COUNT);
    assign empty     = (count_reg == '0);
    assign head      = fifo_mem[rd_ptr_reg];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push      = wr_txdata && (!full || pop);

    always_comb begin
        overflow_next = overflow_reg;
        if (wr_status)
            overflow_next = 1'b0;
        if (wr_txdata && full && !pop)
            overflow_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= din[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
                count_reg <= count_reg + (PTR_W + 1)'(1);
            else if (pop && !push)
                count_reg <= count_reg - (PTR_W + 1)'(1);
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tx_next    = tx_reg;
        baud_next  = baud_reg;
        shift_next = shift_reg;
        bit_next   = bit_reg;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        pop = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty)
                    pop = 1'b1;
            end
            START: begin
                if (baud_reg == '0) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                    baud_next  = BAUD_RELOAD;
                    bit_next   = 3'd0;
                end else begin
                    baud_next = baud_reg - CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_reg == '0) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                        bit_next   = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_reg == '0) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                    baud_next  = BAUD_RELOAD;
                end else begin
                    baud_next = baud_reg - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_reg == '0) begin
                    if (!empty)
                        pop = 1'b1;
                    else
                        state_next = IDLE;
                end else begin
                    baud_next = baud_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Loading the next byte starts its start bit immediately, giving gapless frames.
        if (pop) begin
            state_next = START;
            tx_next    = 1'b0;
            shift_next = head;
            baud_next  = BAUD_RELOAD;
`ifdef UART_TX_PARITY_EN
            parity_next = ^head;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
            baud_reg  <= '0;
            shift_reg <= '0;
            bit_reg   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            tx_reg    <= tx_next;
            baud_reg  <= baud_next;
            shift_reg <= shift_next;
            bit_reg   <= bit_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign tx      = tx_reg;
    assign tx_busy = (state_reg != IDLE) || !empty;

    always_comb begin
        dout = 32'b0;
        if (R_en && (addr == STATUS_ADDR))
            dout = {28'b0, overflow_reg, tx_busy, empty, full};
        else if (R_en && (addr == TXDATA_ADDR))
            dout = {24'b0, head};
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: queued expected bytes are checked against frames decoded off tx.
// Build with UART_TX_PARITY_EN to also check the parity bit and 11-bit frames.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] STAT = BASE + 32'd4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        W_en = 1'b0;
    logic        R_en = 1'b0;
    logic [31:0] addr = 32'b0;
    logic [2:0]  RW_type = 3'b010;
    logic [31:0] din = 32'b0;
    logic [31:0] dout;
    logic        tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .W_en   (W_en),
        .R_en   (R_en),
        .addr   (addr),
        .RW_type(RW_type),
        .din    (din),
        .dout   (dout),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Line monitor: captures one full frame of per-cycle samples after each falling start edge.
    int   cyc = 0;
    int   last_end = -1000;
    int   mon_gap = -1;
    int   mon_idx = 0;
    bit   mon_active = 1'b0;
    int   frames_seen = 0;
    logic last_parity = 1'b0;
    logic samp [FB*CPB];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx == 1'b0) begin
                mon_active = 1'b1;
                mon_idx    = 0;
                mon_gap    = cyc - last_end - 1;
            end
            if (mon_active) begin
                samp[mon_idx] = tx;
                mon_idx++;
                if (mon_idx == FB*CPB) begin
                    int nbad;
                    logic [7:0] data;
                    nbad = 0;
                    for (int b = 0; b < FB; b++)
                        for (int s = 1; s < CPB; s++)
                            if (samp[b*CPB+s] !== samp[b*CPB]) nbad++;
                    for (int i = 0; i < 8; i++)
                        data[i] = samp[(1+i)*CPB];
                    chk("bit_hold", nbad, 0);
                    chk("stop_bit", {31'b0, samp[(FB-1)*CPB]}, 1);
`ifdef UART_TX_PARITY_EN
                    last_parity = samp[9*CPB];
                    chk("parity_bit", {31'b0, last_parity}, {31'b0, ^data});
`endif
                    chk("sb_pending", {31'b0, exp_q.size() > 0}, 1);
                    if (exp_q.size() > 0)
                        chk("frame_data", {24'b0, data}, {24'b0, exp_q.pop_front()});
                    $display("frame %0d data=%h gap=%0d", frames_seen, data, mon_gap);
                    mon_active = 1'b0;
                    last_end   = cyc;
                    frames_seen++;
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        W_en = 1'b1; addr = a; din = d;
        @(negedge clk);
        W_en = 1'b0;
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic wr_burst(input logic [31:0] a, input byte_q_t bq);
        foreach (bq[i]) begin
            @(negedge clk);
            W_en = 1'b1; addr = a; din = {24'b0, bq[i]};
        end
        @(negedge clk);
        W_en = 1'b0;
        $display("burst write addr=%h count=%0d", a, bq.size());
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        R_en = 1'b1; addr = a;
        #1;
        d = dout;
        R_en = 1'b0;
        $display("read addr=%h data=%h", a, d);
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_seen < target; i++) begin
            @(negedge clk);
            #1;
        end
        chk("frames_done", frames_seen, target);
    endtask

    initial begin
        logic [31:0] rdata;
        byte_q_t     bq;
        int          base_frames;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 1);
        chk("rst_busy", {31'b0, tx_busy}, 0);
        rd(STAT, rdata);
        chk("rst_status", rdata, 32'h0000_0002);
        rst_n = 1'b1;

        // Single frame 0x55, start latency and busy fall
        exp_q.push_back(8'h55);
        wr(TXD, 32'h55);
        chk("tx_idle_k", {31'b0, tx}, 1);
        @(negedge clk);
        chk("tx_start_k1", {31'b0, tx}, 0);
        chk("busy_in_frame", {31'b0, tx_busy}, 1);
        wait_frames(1, 200);
        chk("busy_at_stop", {31'b0, tx_busy}, 1);
        @(negedge clk); #1;
        chk("busy_after_stop", {31'b0, tx_busy}, 0);

        // Back-to-back frames
        bq = {8'hA1, 8'h3C};
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'h3C);
        wr_burst(TXD, bq);
        wait_frames(3, 400);
        chk("b2b_gap", mon_gap, 0);

        // Overflow: 10 writes, 9 accepted
        bq = {};
        for (int i = 0; i < 10; i++) begin
            bq.push_back(8'h10 + 8'(i));
            if (i < 9) exp_q.push_back(8'h10 + 8'(i));
        end
        wr_burst(TXD, bq);
        rd(STAT, rdata);
        chk("status_ovf_full", rdata, 32'h0000_000D);
        wr(STAT, 32'h0);
        rd(STAT, rdata);
        chk("ovf_cleared", {31'b0, rdata[3]}, 0);
        chk("status_after_clr", rdata, 32'h0000_0005);
        wait_frames(12, 1000);

        // Unmapped addresses and TXDATA head read
        wr(BASE + 32'd8, 32'hAA);
        repeat (2) @(negedge clk);
        rd(STAT, rdata);
        chk("unmapped_no_push", rdata, 32'h0000_0002);
        rd(BASE + 32'd12, rdata);
        chk("unmapped_read", rdata, 32'h0);
        addr = STAT; #1;
        chk("no_ren_read", dout, 32'h0);
        bq = {8'h11, 8'h7E};
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h7E);
        wr_burst(TXD, bq);
        rd(TXD, rdata);
        chk("txdata_head", rdata, 32'h0000_007E);
        wait_frames(14, 400);

`ifdef UART_TX_PARITY_EN
        // Parity frame 0x07
        exp_q.push_back(8'h07);
        wr(TXD, 32'h07);
        wait_frames(15, 300);
        chk("parity_07", {31'b0, last_parity}, 1);
`endif

        // Reset during data bit 3
        exp_q.push_back(8'hC3);
        wr(TXD, 32'hC3);
        for (int i = 0; i < 200 && !(mon_active && mon_idx >= 4*CPB + 2); i++) begin
            @(negedge clk);
            #1;
        end
        chk("reached_bit3", {31'b0, mon_active && mon_idx >= 4*CPB + 2}, 1);
        chk("tx_bit3", {31'b0, tx}, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {31'b0, tx}, 1);
        chk("async_rst_busy", {31'b0, tx_busy}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(STAT, rdata);
        chk("status_post_rst", rdata, 32'h0000_0002);
        base_frames = frames_seen;
        repeat (100) @(negedge clk);
        chk("no_residual_frame", frames_seen, base_frames);
        chk("line_idle", {31'b0, tx}, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0400, word-aligned base of the two-register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, the number of clk cycles per serial bit (minimum 2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, the number of TX FIFO entries (power of two, minimum 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port W_en, input, 1, core store strobe.
REQ-007 SHALL have port R_en, input, 1, core load strobe.
REQ-008 SHALL have port addr, input, 32, core data address.
REQ-009 SHALL have port RW_type, input, 3, core access size code (accepted, ignored).
REQ-010 SHALL have port din, input, 32, core store data.
REQ-011 SHALL have port dout, output, 32, load data, combinational.
REQ-012 SHALL have port tx, output, 1, serial line, registered, idle high.
REQ-013 SHALL have port tx_busy, output, 1, high while a frame is on the line or the FIFO is non-empty.

Function
REQ-014 SHALL decode TXDATA at BASE_ADDR and STATUS at BASE_ADDR+4; all other addresses are ignored.
REQ-015 SHALL, on W_en with addr==TXDATA at a rising edge, push din[7:0] into the FIFO if it is not full.
REQ-016 SHALL drop a TXDATA write while the FIFO is full and set the sticky overflow flag, except when a pop occurs in the same cycle, in which case the push is accepted.
REQ-017 SHALL clear the overflow flag on any W_en write to STATUS; simultaneous set and clear SHALL leave the flag set.
REQ-018 SHALL drive dout = {28'b0, overflow, busy, empty, full} when R_en and addr==STATUS, the FIFO head byte zero-extended when R_en and addr==TXDATA, and 32'b0 otherwise; reads SHALL have no side effects.
REQ-019 SHALL implement the FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-029).
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop the head into a shift register at the next edge, enter START, and drive tx=0.
REQ-021 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a baud counter that reloads at every bit boundary.
REQ-022 SHALL, in DATA, send 8 bits LSB first, then enter STOP with tx=1.
REQ-023 SHALL, at the end of STOP, go directly to START if the FIFO is non-empty (back-to-back frames, no idle gap), else go to IDLE.
REQ-024 SHALL, after a write to an empty FIFO in IDLE at edge k, drop tx low at edge k+1.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH and track occupancy with a count 0..FIFO_DEPTH; full = count==FIFO_DEPTH, empty = count==0.

Reset
REQ-026 SHALL, on rst_n low, immediately force tx=1, FSM=IDLE, FIFO empty, overflow=0, counters=0, and tx_busy=0, independent of clk.
REQ-027 SHALL abort any in-flight frame when reset is asserted mid-frame, with no completion after release; the line returns high at once.
REQ-028 SHALL begin normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro UART_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP that sends one even-parity bit (XOR of the 8 data bits), making 11-bit frames; without the macro, frames SHALL be 10 bits and no PARITY state exists.

Verification
REQ-030 SHALL cover this case: with CLKS_PER_BIT=4, write 8'h55 to TXDATA -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; tx_busy falls after STOP.
REQ-031 SHALL cover this case: write 8'hA1 then 8'h3C on consecutive cycles -> two frames with no idle cycles between the STOP of the first and the START of the second.
REQ-032 SHALL cover this case: with FIFO_DEPTH=8, do 10 writes while the line is busy -> 9 bytes transmitted (1 popped and 8 queued), STATUS reads 32'h0000_000D (overflow, busy, full); a write to STATUS then gives bit3=0.
REQ-033 SHALL cover this case: assert rst_n low during DATA bit 3 -> tx=1 in the same cycle, STATUS=32'h0000_0002 after release, and no residual frame.
REQ-034 SHALL cover this case: write to BASE_ADDR+8 and read BASE_ADDR+12 -> no push, dout=0; a read of TXDATA with the FIFO holding 8'h7E -> dout=32'h0000_007E.
REQ-035 SHALL cover this case: with UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1 before STOP, frame length 11 bit-times.
